// File: rtl/axis_frame_arb2_pkg.sv
// Shared types and constants for the frame-aware 2:1 AXI-Stream merger.
package axis_frame_arb2_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant0 = 2'd1,
    StGrant1 = 2'd2
  } arb_state_e;

  localparam logic ArbRr    = 1'b0;
  localparam logic ArbFixed = 1'b1;

endpackage

// File: rtl/axis_frame_arb2_if.sv
// Single AXI-Stream link; master drives payload, slave drives tready.
interface axis_frame_arb2_if #(
  parameter int unsigned DATA_W = 32
);
  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_frame_arb2_reg_slice.sv
// Single registered AXI-Stream stage; ready is combinational from the downstream ready.
module axis_reg_slice #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              axis_clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
      last_q  <= in_last;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_frame_arb2.sv
// Frame-aware 2:1 AXI-Stream merger: arbitrates only at frame boundaries, one output register.
module axis_frame_arb2
  import axis_frame_arb2_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 axis_clk,
  input  logic                 rst_n,
  axis_frame_arb2_if.slave     s0,
  axis_frame_arb2_if.slave     s1,
  axis_frame_arb2_if.master    m,
  input  logic                 arb_mode,
  input  logic [1:0]           chn_en,
  output logic                 grant_chn,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_cnt0,
  output logic [CNT_W-1:0]     frame_cnt1,
  output logic [CNT_W-1:0]     last_len
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  fc0_q, fc0_d;
  logic [CNT_W-1:0]  fc1_q, fc1_d;

  logic [1:0]        cand;
  logic              pick1;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic              slice_ready;
  logic              accept;

  assign cand      = {s1.tvalid & chn_en[1], s0.tvalid & chn_en[0]};
  // With both channels requesting, round-robin serves the one not served last.
  assign pick1     = (arb_mode == ArbRr) & ~grant_q;
  assign busy      = (state_q != StIdle);
  assign sel_valid = busy & (grant_q ? s1.tvalid : s0.tvalid);
  assign sel_data  = grant_q ? s1.tdata : s0.tdata;
  assign sel_last  = grant_q ? s1.tlast : s0.tlast;
  assign accept    = sel_valid & slice_ready;
  assign s0.tready = (state_q == StGrant0) & slice_ready;
  assign s1.tready = (state_q == StGrant1) & slice_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        case (cand)
          2'b01:   begin state_d = StGrant0; grant_d = 1'b0; end
          2'b10:   begin state_d = StGrant1; grant_d = 1'b1; end
          2'b11:   begin state_d = pick1 ? StGrant1 : StGrant0; grant_d = pick1; end
          default: ;
        endcase
      end
      StGrant0, StGrant1: begin
        if (accept && sel_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    fc0_d = fc0_q;
    fc1_d = fc1_q;
    if (accept) begin
      if (sel_last) begin
        len_d = (cnt_q == CntMax) ? CntMax : cnt_q + 1'b1;
        cnt_d = '0;
        if (grant_q) fc1_d = fc1_q + 1'b1;
        else         fc0_d = fc0_q + 1'b1;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      fc0_q   <= '0;
      fc1_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      fc0_q   <= fc0_d;
      fc1_q   <= fc1_d;
    end
  end

  assign grant_chn  = grant_q;
  assign frame_cnt0 = fc0_q;
  assign frame_cnt1 = fc1_q;
  assign last_len   = len_q;

  axis_reg_slice #(
    .DATA_W (DATA_W)
  ) u_out_slice (
    .axis_clk  (axis_clk),
    .rst_n     (rst_n),
    .in_valid  (sel_valid),
    .in_data   (sel_data),
    .in_last   (sel_last),
    .in_ready  (slice_ready),
    .out_valid (m.tvalid),
    .out_data  (m.tdata),
    .out_last  (m.tlast),
    .out_ready (m.tready)
  );

endmodule

// File: tb/tb_axis_frame_arb2.sv
// Self-checking bench for axis_frame_arb2: frame-level reference model with randomized stimulus.
module tb_axis_frame_arb2;
  import axis_frame_arb2_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CMAX   = (1 << CNT_W) - 1;

  logic             axis_clk = 1'b0;
  logic             rst_n    = 1'b0;
  logic             arb_mode;
  logic [1:0]       chn_en;
  logic             grant_chn;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt0, frame_cnt1, last_len;

  axis_frame_arb2_if #(.DATA_W(DATA_W)) s0_if ();
  axis_frame_arb2_if #(.DATA_W(DATA_W)) s1_if ();
  axis_frame_arb2_if #(.DATA_W(DATA_W)) m_if ();

  axis_frame_arb2 #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .axis_clk   (axis_clk),
    .rst_n      (rst_n),
    .s0         (s0_if),
    .s1         (s1_if),
    .m          (m_if),
    .arb_mode   (arb_mode),
    .chn_en     (chn_en),
    .grant_chn  (grant_chn),
    .busy       (busy),
    .frame_cnt0 (frame_cnt0),
    .frame_cnt1 (frame_cnt1),
    .last_len   (last_len)
  );

  always #5 axis_clk = ~axis_clk;

  // Source beats are {last, data}; expected output entries are {chn, last, data}.
  logic [DATA_W:0]   q0[$], q1[$], mq0[$], mq1[$];
  logic [DATA_W+1:0] exp_q[$];
  logic [CNT_W-1:0]  m_fc0, m_fc1, m_len;
  logic              m_grant;
  int                checks, errors, cyc, pop0, rdy_pct;
  int                out_cycs[$];
  bit                hs0, hs1, prev_stall, rdy_toggle;
  logic [DATA_W-1:0] prev_data;

  task automatic add_frame(input int ch, input int len, input bit rnd,
                           input logic [DATA_W-1:0] base);
    for (int b = 0; b < len; b++) begin
      logic [DATA_W:0] beat;
      beat = {(b == len - 1), rnd ? DATA_W'($urandom) : base + DATA_W'(b)};
      if (ch == 0) begin q0.push_back(beat); mq0.push_back(beat); end
      else         begin q1.push_back(beat); mq1.push_back(beat); end
    end
  endtask

  // Frame-level arbitration: sources are always valid while they have frames queued.
  task automatic model_serve(input logic [1:0] en, input logic mode);
    bit c0, c1, pick;
    int n;
    logic [DATA_W:0] beat;
    c0 = (mq0.size() > 0) && en[0];
    c1 = (mq1.size() > 0) && en[1];
    while (c0 || c1) begin
      if (c0 && c1) pick = (mode == ArbFixed) ? 1'b0 : !m_grant;
      else          pick = c1;
      m_grant = pick;
      n = 0;
      do begin
        beat = pick ? mq1.pop_front() : mq0.pop_front();
        exp_q.push_back({pick, beat});
        n++;
      end while (!beat[DATA_W]);
      m_len = (n > CMAX) ? CNT_W'(CMAX) : CNT_W'(n);
      if (pick) m_fc1 = m_fc1 + 1'b1;
      else      m_fc0 = m_fc0 + 1'b1;
      c0 = (mq0.size() > 0) && en[0];
      c1 = (mq1.size() > 0) && en[1];
    end
  endtask

  // One clock: drive sources and m_tready on the falling edge, then observe before the rise.
  task automatic step();
    logic [DATA_W+1:0] e;
    logic [1:0] exp_rdy;
    @(negedge axis_clk);
    cyc++;
    if (hs0) begin q0.delete(0); pop0++; end
    if (hs1) q1.delete(0);
    s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0;
    s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0;
    if (q0.size() > 0) begin
      s0_if.tvalid = 1'b1; s0_if.tdata = q0[0][DATA_W-1:0]; s0_if.tlast = q0[0][DATA_W];
    end
    if (q1.size() > 0) begin
      s1_if.tvalid = 1'b1; s1_if.tdata = q1[0][DATA_W-1:0]; s1_if.tlast = q1[0][DATA_W];
    end
    m_if.tready = rdy_toggle ? cyc[0] : ($urandom_range(0, 99) < rdy_pct);
    #1;
    hs0 = s0_if.tvalid && s0_if.tready;
    hs1 = s1_if.tvalid && s1_if.tready;
    if (prev_stall) begin
      checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data) begin
        errors++;
        $display("FAIL stall_hold: valid=%b data=%h, expected valid=1 data=%h",
                 m_if.tvalid, m_if.tdata, prev_data);
      end
    end
    exp_rdy[0] = busy && !grant_chn && !(m_if.tvalid && !m_if.tready);
    exp_rdy[1] = busy &&  grant_chn && !(m_if.tvalid && !m_if.tready);
    checks++;
    if ({s1_if.tready, s0_if.tready} !== exp_rdy) begin
      errors++;
      $display("FAIL tready: s1/s0=%b%b, expected %b (cyc %0d)",
               s1_if.tready, s0_if.tready, exp_rdy, cyc);
    end
    if (m_if.tvalid && m_if.tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat: unexpected beat data=%h last=%b", m_if.tdata, m_if.tlast);
      end else begin
        e = exp_q.pop_front();
        out_cycs.push_back(cyc);
        if ({m_if.tlast, m_if.tdata} !== e[DATA_W:0]) begin
          errors++;
          $display("FAIL out_beat: last=%b data=%h, expected last=%b data=%h",
                   m_if.tlast, m_if.tdata, e[DATA_W], e[DATA_W-1:0]);
        end
        if (!rdy_toggle && rdy_pct == 100) begin
          checks++;
          if (grant_chn !== e[DATA_W+1]) begin
            errors++;
            $display("FAIL grant_chn: got %b, expected %b", grant_chn, e[DATA_W+1]);
          end
        end
      end
    end
    prev_stall = m_if.tvalid && !m_if.tready;
    prev_data  = m_if.tdata;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && n < 3000) begin
      step();
      n++;
    end
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d beats outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0;
    s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0;
    m_if.tready = 1'b1; chn_en = 2'b11; arb_mode = ArbRr;
    #12;
    checks++;
    if ({m_if.tvalid, m_if.tdata, m_if.tlast, grant_chn, busy, frame_cnt0, frame_cnt1,
         last_len, s0_if.tready, s1_if.tready} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h last=%b grant=%b busy=%b fc0=%0d fc1=%0d len=%0d rdy=%b%b, expected all 0",
               m_if.tvalid, m_if.tdata, m_if.tlast, grant_chn, busy, frame_cnt0, frame_cnt1,
               last_len, s1_if.tready, s0_if.tready);
    end
    @(negedge axis_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    int c0;
    rdy_pct = 100;
    add_frame(0, 4, 1'b0, 32'h11);
    model_serve(chn_en, arb_mode);
    out_cycs.delete();
    c0 = cyc + 1;
    drain("single");
    checks++;
    if (out_cycs.size() != 4 || out_cycs[0] != c0 + 2 || out_cycs[3] != c0 + 5) begin
      errors++;
      $display("FAIL single_timing: %0d beats first at cyc %0d, expected 4 beats from cyc %0d",
               out_cycs.size(), (out_cycs.size() > 0) ? out_cycs[0] : -1, c0 + 2);
    end
    checks++;
    if (frame_cnt0 !== m_fc0 || frame_cnt1 !== m_fc1 || last_len !== m_len) begin
      errors++;
      $display("FAIL single_status: fc0=%0d fc1=%0d len=%0d, expected %0d %0d %0d",
               frame_cnt0, frame_cnt1, last_len, m_fc0, m_fc1, m_len);
    end
  endtask

  task automatic test_round_robin();
    arb_mode = ArbRr;
    for (int i = 0; i < 2; i++) begin
      add_frame(0, 3, 1'b1, '0);
      add_frame(1, 3, 1'b1, '0);
    end
    model_serve(chn_en, arb_mode);
    drain("rr");
    checks++;
    if (frame_cnt0 !== m_fc0 || frame_cnt1 !== m_fc1 || last_len !== m_len) begin
      errors++;
      $display("FAIL rr_status: fc0=%0d fc1=%0d len=%0d, expected %0d %0d %0d",
               frame_cnt0, frame_cnt1, last_len, m_fc0, m_fc1, m_len);
    end
  endtask

  task automatic test_fixed_priority();
    arb_mode = ArbFixed;
    for (int i = 0; i < 3; i++) add_frame(0, 3, 1'b1, '0);
    for (int i = 0; i < 2; i++) add_frame(1, 3, 1'b1, '0);
    model_serve(chn_en, arb_mode);
    drain("fixed");
    checks++;
    if (frame_cnt0 !== m_fc0 || frame_cnt1 !== m_fc1 || last_len !== m_len) begin
      errors++;
      $display("FAIL fixed_status: fc0=%0d fc1=%0d len=%0d, expected %0d %0d %0d",
               frame_cnt0, frame_cnt1, last_len, m_fc0, m_fc1, m_len);
    end
    arb_mode = ArbRr;
  endtask

  task automatic test_backpressure();
    rdy_toggle = 1'b1;
    add_frame(0, 8, 1'b1, '0);
    model_serve(chn_en, arb_mode);
    drain("bp");
    rdy_toggle = 1'b0;
    checks++;
    if (frame_cnt0 !== m_fc0 || frame_cnt1 !== m_fc1 || last_len !== m_len) begin
      errors++;
      $display("FAIL bp_status: fc0=%0d fc1=%0d len=%0d, expected %0d %0d %0d",
               frame_cnt0, frame_cnt1, last_len, m_fc0, m_fc1, m_len);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      arb_mode = 1'($urandom_range(0, 1));
      rdy_pct  = $urandom_range(40, 90);
      for (int f = 0; f < int'($urandom_range(1, 4)); f++)
        add_frame(0, $urandom_range(1, 6), 1'b1, '0);
      for (int f = 0; f < int'($urandom_range(1, 4)); f++)
        add_frame(1, $urandom_range(1, 6), 1'b1, '0);
      model_serve(chn_en, arb_mode);
      drain("random");
      checks++;
      if (frame_cnt0 !== m_fc0 || frame_cnt1 !== m_fc1 || last_len !== m_len) begin
        errors++;
        $display("FAIL random_status: fc0=%0d fc1=%0d len=%0d, expected %0d %0d %0d",
                 frame_cnt0, frame_cnt1, last_len, m_fc0, m_fc1, m_len);
      end
    end
    arb_mode = ArbRr;
    rdy_pct  = 100;
  endtask

  task automatic test_enable();
    int n;
    chn_en = 2'b01;
    add_frame(1, 3, 1'b1, '0);
    repeat (8) begin
      step();
      checks++;
      if (busy !== 1'b0 || m_if.tvalid !== 1'b0) begin
        errors++;
        $display("FAIL en_idle: busy=%b m_tvalid=%b, expected 0 0", busy, m_if.tvalid);
      end
    end
    add_frame(0, 5, 1'b1, '0);
    model_serve(chn_en, arb_mode);
    pop0 = 0;
    n = 0;
    while (pop0 < 2 && n < 100) begin step(); n++; end
    chn_en = 2'b00;
    drain("en_mid");
    add_frame(0, 2, 1'b1, '0);
    repeat (8) begin
      step();
      checks++;
      if (busy !== 1'b0 || m_if.tvalid !== 1'b0) begin
        errors++;
        $display("FAIL en_off: busy=%b m_tvalid=%b, expected 0 0", busy, m_if.tvalid);
      end
    end
    chn_en = 2'b11;
    model_serve(chn_en, arb_mode);
    drain("en_restore");
    checks++;
    if (frame_cnt0 !== m_fc0 || frame_cnt1 !== m_fc1 || last_len !== m_len) begin
      errors++;
      $display("FAIL en_status: fc0=%0d fc1=%0d len=%0d, expected %0d %0d %0d",
               frame_cnt0, frame_cnt1, last_len, m_fc0, m_fc1, m_len);
    end
  endtask

  task automatic test_saturate_wrap();
    add_frame(0, 20, 1'b1, '0);
    model_serve(chn_en, arb_mode);
    drain("sat");
    checks++;
    if (frame_cnt0 !== m_fc0 || last_len !== m_len) begin
      errors++;
      $display("FAIL sat_status: fc0=%0d len=%0d, expected %0d %0d",
               frame_cnt0, last_len, m_fc0, m_len);
    end
    for (int i = 0; i < 17; i++) add_frame(0, 1, 1'b1, '0);
    model_serve(chn_en, arb_mode);
    drain("wrap");
    checks++;
    if (frame_cnt0 !== m_fc0 || frame_cnt1 !== m_fc1 || last_len !== m_len) begin
      errors++;
      $display("FAIL wrap_status: fc0=%0d fc1=%0d len=%0d, expected %0d %0d %0d",
               frame_cnt0, frame_cnt1, last_len, m_fc0, m_fc1, m_len);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    add_frame(0, 6, 1'b1, '0);
    model_serve(chn_en, arb_mode);
    pop0 = 0;
    n = 0;
    while (pop0 < 3 && n < 100) begin step(); n++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_if.tvalid, m_if.tdata, m_if.tlast, grant_chn, busy, frame_cnt0, frame_cnt1,
         last_len, s0_if.tready, s1_if.tready} !== '0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=%h last=%b grant=%b busy=%b fc0=%0d fc1=%0d len=%0d rdy=%b%b, expected all 0",
               m_if.tvalid, m_if.tdata, m_if.tlast, grant_chn, busy, frame_cnt0, frame_cnt1,
               last_len, s1_if.tready, s0_if.tready);
    end
    q0.delete(); q1.delete(); mq0.delete(); mq1.delete(); exp_q.delete();
    hs0 = 1'b0; hs1 = 1'b0; prev_stall = 1'b0;
    m_fc0 = '0; m_fc1 = '0; m_len = '0; m_grant = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    add_frame(0, 2, 1'b1, '0);
    model_serve(chn_en, arb_mode);
    drain("post_reset");
    checks++;
    if (frame_cnt0 !== m_fc0 || frame_cnt1 !== m_fc1 || last_len !== m_len) begin
      errors++;
      $display("FAIL post_reset_status: fc0=%0d fc1=%0d len=%0d, expected %0d %0d %0d",
               frame_cnt0, frame_cnt1, last_len, m_fc0, m_fc1, m_len);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; pop0 = 0; rdy_pct = 100;
    hs0 = 1'b0; hs1 = 1'b0; prev_stall = 1'b0; rdy_toggle = 1'b0; prev_data = '0;
    m_fc0 = '0; m_fc1 = '0; m_len = '0; m_grant = 1'b0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_random();
    test_enable();
    test_saturate_wrap();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
